// File: rtl/pc_seq_ctrl_pkg.sv
// rtl/pc_seq_ctrl_pkg.sv - shared CPU control constants, state encoding and strobe bundle
package pc_seq_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_BRANCH = 3'd3,
    ST_JUMP   = 3'd4,
    ST_EXEC   = 3'd5,
    ST_EXCEPT = 3'd6
  } state_t;

  localparam logic [1:0] PCSRC_PC4    = 2'b00;
  localparam logic [1:0] PCSRC_BRANCH = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_EXC    = 2'b11;

  localparam logic [1:0] CAUSE_INVALID = 2'b00;
  localparam logic [1:0] CAUSE_OVF     = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_SUB = 2'b01;

  localparam logic [1:0] ALUB_REG    = 2'b00;
  localparam logic [1:0] ALUB_FOUR   = 2'b01;
  localparam logic [1:0] ALUB_OFFSET = 2'b11;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // Registered per-state strobes; the fetch-complete and branch-taken terms are overlaid in the top.
  typedef struct packed {
    logic [1:0] pc_source;
    logic       pc_write;
    logic       mem_read;
    logic       iord;
    logic       link_write;
    logic       epc_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;

  // Where DECODE sends each opcode; anything unrecognised raises an invalid-opcode exception.
  function automatic state_t decode_target(input logic [5:0] op);
    case (op)
      OP_BEQ, OP_BNE:                              return ST_BRANCH;
      OP_J, OP_JAL:                                return ST_JUMP;
      OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_LUI:     return ST_EXEC;
      default:                                     return ST_EXCEPT;
    endcase
  endfunction

endpackage

// File: rtl/seq_cycle_counter.sv
// rtl/seq_cycle_counter.sv - loadable down-counter with terminal flag for sequencer waits
module seq_cycle_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         dec,
  output logic         terminal
);

  logic [W-1:0] count;

  // Load wins over decrement; the count parks at zero once terminal.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && !terminal) begin
      count <= count - W'(1);
    end
  end

  assign terminal = (count == '0);

endmodule

// File: rtl/pc_seq_ctrl.sv
// rtl/pc_seq_ctrl.sv - multicycle CPU PC sequencing control FSM
module pc_seq_ctrl
  import pc_seq_ctrl_pkg::*;
#(
  parameter int MEM_WAIT   = 2,
  parameter int EX_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       overflow,
  input  logic       ex_done,
  output logic [1:0] pc_source,
  output logic       pc_write,
  output logic       ir_write,
  output logic       mem_read,
  output logic       iord,
  output logic       link_write,
  output logic       epc_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] cause
);

  state_t     state;
  state_t     nxt;
  logic [1:0] cause_q;
  logic [1:0] cause_nxt;
  ctrl_t      ctrl_q;
  ctrl_t      ctrl_nxt;

  logic wait_term;
  logic exec_term;
  logic fetch_last;
  logic branch_taken;

  // Each counter is loaded on the edge that enters its state, so the first cycle already sees the full count.
  seq_cycle_counter #(.W(3)) u_wait_cnt (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       ((nxt == ST_FETCH) && (state != ST_FETCH)),
    .load_value (3'(MEM_WAIT)),
    .dec        (state == ST_FETCH),
    .terminal   (wait_term)
  );

  // Loaded with EX_TIMEOUT-1 so terminal coincides with the EX_TIMEOUT-th EXEC cycle.
  seq_cycle_counter #(.W(8)) u_exec_cnt (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       ((nxt == ST_EXEC) && (state != ST_EXEC)),
    .load_value (8'(EX_TIMEOUT - 1)),
    .dec        (state == ST_EXEC),
    .terminal   (exec_term)
  );

  // Next-state and exception cause; ex_done takes priority over a simultaneous timeout.
  always_comb begin
    nxt       = state;
    cause_nxt = cause_q;
    case (state)
      ST_RESET:  nxt = ST_FETCH;
      ST_FETCH:  if (wait_term) nxt = ST_DECODE;
      ST_DECODE: begin
        nxt = decode_target(opcode);
        if (nxt == ST_EXCEPT) cause_nxt = CAUSE_INVALID;
      end
      ST_BRANCH, ST_JUMP, ST_EXCEPT: nxt = ST_FETCH;
      ST_EXEC: begin
        if (ex_done) begin
          if (overflow) begin
            nxt       = ST_EXCEPT;
            cause_nxt = CAUSE_OVF;
          end else begin
            nxt = ST_FETCH;
          end
        end else if (exec_term) begin
          nxt       = ST_EXCEPT;
          cause_nxt = CAUSE_TIMEOUT;
        end
      end
      default:   nxt = ST_RESET;
    endcase
  end

  // Strobes for the state being entered, so they are registered alongside the state.
  always_comb begin
    ctrl_nxt = CTRL_IDLE;
    case (nxt)
      ST_FETCH: begin
        ctrl_nxt.mem_read = 1'b1;
        ctrl_nxt.iord     = 1'b0;
      end
      ST_DECODE: begin
        ctrl_nxt.alu_src_a = 1'b0;
        ctrl_nxt.alu_src_b = ALUB_OFFSET;
        ctrl_nxt.alu_op    = ALUOP_ADD;
      end
      ST_BRANCH: begin
        ctrl_nxt.alu_src_a = 1'b1;
        ctrl_nxt.alu_src_b = ALUB_REG;
        ctrl_nxt.alu_op    = ALUOP_SUB;
        ctrl_nxt.pc_source = PCSRC_BRANCH;
      end
      ST_JUMP: begin
        ctrl_nxt.pc_source  = PCSRC_JUMP;
        ctrl_nxt.pc_write   = 1'b1;
        ctrl_nxt.link_write = (opcode == OP_JAL);
      end
      ST_EXCEPT: begin
        ctrl_nxt.epc_write = 1'b1;
        ctrl_nxt.pc_write  = 1'b1;
        ctrl_nxt.pc_source = PCSRC_EXC;
      end
      default: ctrl_nxt = CTRL_IDLE;
    endcase
  end

  // State, cause and strobe registers; reset aborts whatever phase is in progress.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= ST_RESET;
      cause_q <= 2'b00;
      ctrl_q  <= CTRL_IDLE;
    end else begin
      state   <= nxt;
      cause_q <= cause_nxt;
      ctrl_q  <= ctrl_nxt;
    end
  end

  // The last fetch cycle latches the IR and advances PC by 4 (PC source and ALU add are already 0).
  assign fetch_last   = (state == ST_FETCH) && wait_term;
  assign branch_taken = (state == ST_BRANCH) && ((opcode == OP_BNE) ? ~zero : zero);

  assign pc_source  = ctrl_q.pc_source;
  assign pc_write   = ctrl_q.pc_write | fetch_last | branch_taken;
  assign ir_write   = fetch_last;
  assign mem_read   = ctrl_q.mem_read;
  assign iord       = ctrl_q.iord;
  assign link_write = ctrl_q.link_write;
  assign epc_write  = ctrl_q.epc_write;
  assign alu_src_a  = ctrl_q.alu_src_a;
  assign alu_src_b  = ctrl_q.alu_src_b | (fetch_last ? ALUB_FOUR : ALUB_REG);
  assign alu_op     = ctrl_q.alu_op;
  assign cause      = cause_q;

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// tb/tb_pc_seq_ctrl.sv - randomized self-checking bench for pc_seq_ctrl
module tb_pc_seq_ctrl;

  localparam int MEM_WAIT   = 2;
  localparam int EX_TIMEOUT = 15;
  localparam logic [5:0] OPS [11] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08,
                                      6'h0F, 6'h23, 6'h2B, 6'h3F, 6'h01};

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [5:0] opcode = 6'h00;
  logic       zero = 1'b0;
  logic       overflow = 1'b0;
  logic       ex_done = 1'b0;
  logic [1:0] pc_source;
  logic       pc_write, ir_write, mem_read, iord, link_write, epc_write, alu_src_a;
  logic [1:0] alu_src_b, alu_op, cause;

  pc_seq_ctrl #(.MEM_WAIT(MEM_WAIT), .EX_TIMEOUT(EX_TIMEOUT)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .opcode     (opcode),
    .zero       (zero),
    .overflow   (overflow),
    .ex_done    (ex_done),
    .pc_source  (pc_source),
    .pc_write   (pc_write),
    .ir_write   (ir_write),
    .mem_read   (mem_read),
    .iord       (iord),
    .link_write (link_write),
    .epc_write  (epc_write),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .cause      (cause)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [1:0] cause_m = 2'b00;

  logic [14:0] obs;
  assign obs = {pc_source, pc_write, ir_write, mem_read, iord, link_write,
                epc_write, alu_src_a, alu_src_b, alu_op, cause};

  task automatic check(input string tag, input logic [14:0] got, input logic [14:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [14:0] ev(input logic [1:0] ps, input logic pw, irw, mr, io, lw, epc, asa,
                                     input logic [1:0] asb, aop);
    return {ps, pw, irw, mr, io, lw, epc, asa, asb, aop, cause_m};
  endfunction

  function automatic logic r();
    return 1'($urandom);
  endfunction

  function automatic bit is_exec(input logic [5:0] op);
    return op inside {6'h00, 6'h08, 6'h23, 6'h2B, 6'h0F};
  endfunction

  task automatic cyc(input string tag, input logic [5:0] op, input logic z, ed, ov, rn,
                     input logic [14:0] exp);
    opcode = op; zero = z; ex_done = ed; overflow = ov; reset_n = rn;
    @(negedge clk);
    check(tag, obs, exp);
    @(posedge clk);
    #1;
  endtask

  task automatic recover();
    cause_m = 2'b00;
    cyc("rst_hold", 6'($urandom), r(), r(), r(), 1'b0, 15'h0);
    cyc("rst_release", 6'($urandom), r(), r(), r(), 1'b1, 15'h0);
  endtask

  task automatic step(input string tag, input logic [5:0] op, input logic z, ed, ov,
                      input logic [14:0] exp, inout int ci, input int rst_at, output bit ab);
    logic rn;
    rn = (ci != rst_at);
    cyc(tag, op, z, ed, ov, rn, exp);
    ci++;
    ab = !rn;
    if (ab) recover();
  endtask

  // One instruction: fetch, decode, then the class-specific phase derived from the opcode.
  task automatic run_instr(input string nm, input logic [5:0] op, input logic z, input int exd,
                           input logic ovf, input int rst_at);
    int ci;
    bit ab;
    ci = 0;
    for (int i = 0; i <= MEM_WAIT; i++) begin
      logic [14:0] e;
      e = (i == MEM_WAIT) ? ev(2'b00, 1, 1, 1, 0, 0, 0, 0, 2'b01, 2'b00)
                          : ev(2'b00, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00);
      step({nm, "_fetch"}, 6'($urandom), r(), r(), r(), e, ci, rst_at, ab);
      if (ab) return;
    end
    step({nm, "_decode"}, op, r(), r(), r(), ev(2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00), ci, rst_at, ab);
    if (ab) return;
    if (op == 6'h04 || op == 6'h05) begin
      step({nm, "_branch"}, op, z, r(), r(),
           ev(2'b01, (op == 6'h04) ? z : ~z, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01), ci, rst_at, ab);
    end else if (op == 6'h02 || op == 6'h03) begin
      step({nm, "_jump"}, op, r(), r(), r(),
           ev(2'b10, 1, 0, 0, 0, op == 6'h03, 0, 0, 2'b00, 2'b00), ci, rst_at, ab);
    end else if (is_exec(op)) begin
      for (int k = 1; k <= EX_TIMEOUT; k++) begin
        bit fire;
        fire = (k == exd);
        step({nm, "_exec"}, 6'($urandom), r(), fire, fire ? ovf : r(),
             ev(2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00), ci, rst_at, ab);
        if (ab) return;
        if (fire) begin
          if (ovf) begin
            cause_m = 2'b01;
            step({nm, "_exc_ovf"}, 6'($urandom), r(), r(), r(),
                 ev(2'b11, 1, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00), ci, rst_at, ab);
          end
          return;
        end
        if (k == EX_TIMEOUT) begin
          cause_m = 2'b10;
          step({nm, "_exc_tmo"}, 6'($urandom), r(), r(), r(),
               ev(2'b11, 1, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00), ci, rst_at, ab);
        end
      end
    end else begin
      cause_m = 2'b00;
      step({nm, "_exc_inv"}, 6'($urandom), r(), r(), r(),
           ev(2'b11, 1, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00), ci, rst_at, ab);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    cyc("reset", 6'h3F, 1'b1, 1'b1, 1'b1, 1'b0, 15'h0);
    cyc("release", 6'h3F, 1'b1, 1'b1, 1'b1, 1'b1, 15'h0);

    run_instr("j",        6'h02, 1'b0, 0, 1'b0, -1);
    run_instr("beq_z1",   6'h04, 1'b1, 0, 1'b0, -1);
    run_instr("beq_z0",   6'h04, 1'b0, 0, 1'b0, -1);
    run_instr("bne_z1",   6'h05, 1'b1, 0, 1'b0, -1);
    run_instr("bne_z0",   6'h05, 1'b0, 0, 1'b0, -1);
    run_instr("invalid",  6'h3F, 1'b0, 0, 1'b0, -1);
    run_instr("ovf4",     6'h00, 1'b0, 4, 1'b1, -1);
    run_instr("timeout",  6'h00, 1'b0, 99, 1'b0, -1);
    run_instr("done_tmo", 6'h23, 1'b0, EX_TIMEOUT, 1'b0, -1);
    run_instr("done1",    6'h08, 1'b0, 1, 1'b0, -1);
    run_instr("jal",      6'h03, 1'b0, 0, 1'b0, -1);
    run_instr("rst_fetch", 6'h23, 1'b0, 5, 1'b0, 1);
    run_instr("after_rf",  6'h02, 1'b0, 0, 1'b0, -1);
    run_instr("ovf_pre",   6'h00, 1'b0, 2, 1'b1, -1);
    run_instr("rst_exec",  6'h2B, 1'b0, 99, 1'b0, MEM_WAIT + 1 + 1 + 2);
    run_instr("after_re",  6'h0F, 1'b0, 3, 1'b0, -1);

    for (int n = 0; n < 80; n++) begin
      logic [5:0] op;
      int rst_at;
      op = ($urandom_range(0, 1) == 0) ? OPS[$urandom_range(0, 10)] : 6'($urandom);
      rst_at = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 10)) : -1;
      run_instr("rnd", op, r(), int'($urandom_range(1, 20)), r(), rst_at);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
